logic_unit_pipe: RTL
====================

Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit for the ALU datapath; successor to the single-cycle combinational OR/zero-flag block.
- Executes one of eight bitwise operations per accepted transaction.
- Registers the result with zero, all-ones and parity flags.
- Uses valid/ready handshakes on both sides with full back-pressure.
- Accumulate mode replaces operand A with the previous accepted result, so chained reductions (for example, OR over a burst) need no external feedback.

Parameters:
WIDTH, 32, operand/result width in bits (legal 2..64).
PIPE_STAGES, 2, pipeline depth (1 or 2); any other value is an elaboration error.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream transaction valid.
in_ready  output  1  block can accept a transaction.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_op  input  3  operation select.
in_acc  input  1  1 = replace operand A with the accumulator.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_result  output  WIDTH  operation result.
out_zero  output  1  result == 0.
out_ones  output  1  result == all ones.
out_parity  output  1  XOR-reduction of result.

Behaviour:
- Reset (async, rst_n=0):
  - All stage-valid bits, accumulator, out_result and flags clear to 0.
  - out_valid=0.
  - in_ready=1 from the first clock after rst_n deasserts.
  - Reset mid-transaction discards all in-flight data with no partial output.
- Op encoding, with A = in_acc ? acc : in_a and B = in_b:
  - 0 AND, 1 OR, 2 XOR, 3 NOR
  - 4 NAND, 5 XNOR, 6 ANDN (A & ~B), 7 PASS_B.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1 (execute):
  - On accept, the result is computed from A/B and captured into the stage-1 register.
  - acc <= result in the same edge.
  - acc updates only on accept, never on stall.
- Stage 2 (flags), PIPE_STAGES=2 only:
  - Captures the stage-1 result and computes the three flags from it.
  - With PIPE_STAGES=1, flags are computed in stage 1 and stage 1 drives the outputs.
- Latency: PIPE_STAGES cycles from accept edge to out_valid=1 with no stall. Throughput: 1 transaction/cycle.
- Elastic stall:
  - A stage loads when it is empty or its downstream is advancing in the same cycle.
  - in_ready = !s1_valid || s1_advance; in_ready is combinational from out_ready through the pipeline.
  - Under out_ready=0 with all stages full, in_ready=0.
  - While stalled, the outputs and acc hold stable.
- Flag rules:
  - WIDTH-wide compare only; no sign semantics.
  - out_zero and out_ones are mutually exclusive.
  - Flags are meaningful only while out_valid=1 and are held otherwise.
- Simultaneous accept and output transfer in one cycle: no bubble, no loss.
- in_acc=1 on the first transaction after reset uses acc=0.
- Back-to-back in_acc transactions chain in order of acceptance, independent of output stalls.

Optional Feature:
Macro LU_ZCOUNT_EN.
- Defined: adds output zero_count [15:0].
  - Increments on each output transfer with out_zero=1.
  - Saturates at 16'hFFFF.
  - Async-cleared by rst_n.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg: op-code enum lu_op_t (LU_AND..LU_PASSB, 3-bit) and constant LU_OP_W=3, reused by the ALU top-level decoder.
- Sub-module lu_flags (combinational; result in; zero/ones/parity out), instanced in the final stage.

Test Plan:
- Basic ops, WIDTH=32, PIPE_STAGES=2, out_ready=1:
  - A=0xF0F0_0000, B=0x0F0F_0000, op=OR -> out_result=0xFFFF_0000, zero=0, ones=0, parity=0, two cycles after accept.
  - Same A/B with op=AND -> 0x0000_0000, zero=1.
- All-ones: A=0xFFFF_0000, B=0x0000_FFFF, op=XOR -> 0xFFFF_FFFF, ones=1, zero=0; then op=NOR on the same operands -> 0, zero=1.
- Accumulate chain: OR with in_acc=1 and B = 0x1, 0x2, 0x4, 0x8 on consecutive cycles -> results 0x1, 0x3, 0x7, 0xF; parity sequence 1, 0, 1, 0.
- Back-pressure:
  - Hold out_ready=0 for 5 cycles while streaming 4 transactions -> in_ready drops after 2 accepts.
  - No data loss; on release, results emerge in order with one per cycle.
- Reset mid-stream: assert rst_n=0 with 2 transactions in flight -> out_valid=0 immediately; after release, acc=0 and the first in_acc=1 OR with B=0x5 -> 0x5.
- PIPE_STAGES=1 with LU_ZCOUNT_EN defined:
  - 3 zero results and 1 non-zero result -> latency 1 cycle, zero_count=3.
  - Force 65540 zero results -> zero_count=0xFFFF.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit op-code encoding and its width.
package alu_pkg;

  localparam int unsigned LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND   = 3'd0,
    LU_OR    = 3'd1,
    LU_XOR   = 3'd2,
    LU_NOR   = 3'd3,
    LU_NAND  = 3'd4,
    LU_XNOR  = 3'd5,
    LU_ANDN  = 3'd6,
    LU_PASSB = 3'd7
  } lu_op_t;

endpackage

// File: rtl/lu_flags.sv
// Combinational result flags: zero, all-ones and XOR parity.
module lu_flags #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] result_i,
  output logic             zero_o,
  output logic             ones_o,
  output logic             parity_o
);

  assign zero_o   = (result_i == '0);
  assign ones_o   = &result_i;
  assign parity_o = ^result_i;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with accumulate mode and valid/ready on both sides.
// Optional LU_ZCOUNT_EN adds a saturating count of zero-result output transfers.
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [LU_OP_W-1:0] in_op,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_parity
`ifdef LU_ZCOUNT_EN
  ,
  output logic [15:0]        zero_count
`endif
);

  if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
    $error("logic_unit_pipe: PIPE_STAGES must be 1 or 2");
  end
  if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
    $error("logic_unit_pipe: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] op_a, alu_res, acc_q, s1_result_q, flag_src;
  logic             s1_valid_q, s1_valid_d, s1_load, s1_dn_ready, flag_load;
  logic             flag_zero, flag_ones, flag_parity;
  logic             zero_q, ones_q, parity_q;

  assign op_a = in_acc ? acc_q : in_a;

  always_comb begin
    alu_res = '0;
    unique case (lu_op_t'(in_op))
      LU_AND:   alu_res = op_a & in_b;
      LU_OR:    alu_res = op_a | in_b;
      LU_XOR:   alu_res = op_a ^ in_b;
      LU_NOR:   alu_res = ~(op_a | in_b);
      LU_NAND:  alu_res = ~(op_a & in_b);
      LU_XNOR:  alu_res = ~(op_a ^ in_b);
      LU_ANDN:  alu_res = op_a & ~in_b;
      LU_PASSB: alu_res = in_b;
    endcase
  end

  assign in_ready = !s1_valid_q || s1_dn_ready;
  assign s1_load  = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (s1_load)          s1_valid_d = 1'b1;
    else if (s1_dn_ready) s1_valid_d = 1'b0;
  end

  // acc and the stage-1 result share one load enable, so acc never moves on a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_result_q <= '0;
      acc_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_result_q <= alu_res;
        acc_q       <= alu_res;
      end
    end
  end

  if (PIPE_STAGES == 1) begin : g_one
    assign s1_dn_ready = out_ready;
    assign flag_load   = s1_load;
    assign flag_src    = alu_res;
    assign out_valid   = s1_valid_q;
    assign out_result  = s1_result_q;
  end else begin : g_two
    logic             s2_valid_q, s2_load, fin_ready;
    logic [WIDTH-1:0] s2_result_q;

    assign fin_ready   = !s2_valid_q || out_ready;
    assign s2_load     = s1_valid_q && fin_ready;
    assign s1_dn_ready = fin_ready;
    assign flag_load   = s2_load;
    assign flag_src    = s1_result_q;
    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q  <= 1'b0;
        s2_result_q <= '0;
      end else begin
        if (s2_load)        s2_valid_q <= 1'b1;
        else if (out_ready) s2_valid_q <= 1'b0;
        if (s2_load) s2_result_q <= s1_result_q;
      end
    end
  end

  lu_flags #(
    .WIDTH(WIDTH)
  ) u_flags (
    .result_i (flag_src),
    .zero_o   (flag_zero),
    .ones_o   (flag_ones),
    .parity_o (flag_parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q   <= 1'b0;
      ones_q   <= 1'b0;
      parity_q <= 1'b0;
    end else if (flag_load) begin
      zero_q   <= flag_zero;
      ones_q   <= flag_ones;
      parity_q <= flag_parity;
    end
  end

  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = parity_q;

`ifdef LU_ZCOUNT_EN
  logic [15:0] zcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zcnt_q <= '0;
    end else if (out_valid && out_ready && zero_q && (zcnt_q != 16'hFFFF)) begin
      zcnt_q <= zcnt_q + 16'd1;
    end
  end

  assign zero_count = zcnt_q;
`endif

endmodule
